// File: rtl/btb_ctrl_pkg.sv
// Shared types for the BTB update scheduler: queue entry, FSM states and packet packing.
package btb_ctrl_pkg;

  localparam int PKT_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
  } upd_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    PULSE,
    RECOVER
  } sched_state_e;

  // Packet layout: {tag = pc[31:3], index = pc[2:0], target}
  function automatic logic [PKT_W-1:0] pack_upd(input upd_entry_t e);
    return {e.pc[31:3], e.pc[2:0], e.target};
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Update queue for the BTB scheduler: circular buffer with head, next-head and tail read ports
// plus a tail-target overwrite port used when results for the same PC are merged.
module btb_upd_fifo
  import btb_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  upd_entry_t                 push_data,
  input  logic                       pop,
  input  logic                       overwrite,
  input  logic [31:0]                overwrite_target,
  output upd_entry_t                 head,
  output upd_entry_t                 second,
  output logic [31:0]                tail_pc,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  upd_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [PTR_W-1:0] tail_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign rd_next  = rd_ptr + 1'b1;
  assign tail_ptr = wr_ptr - 1'b1;

  assign head    = mem[rd_ptr];
  assign second  = mem[rd_next];
  assign tail_pc = mem[tail_ptr].pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; every read is qualified by count in the parent.
  always_ff @(posedge clk) begin
    if (push_ok)   mem[wr_ptr] <= push_data;
    if (overwrite) mem[tail_ptr].target <= overwrite_target;
  end

endmodule

// File: rtl/btb_update_scheduler.sv
// Queues taken branch resolutions and replays them to the BTB update port as DRIVE/PULSE/RECOVER
// sequences. Optional same-PC merging of the tail entry is enabled by BTB_UPD_COALESCE_EN.
module btb_update_scheduler
  import btb_ctrl_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int STALL_MAX = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       res_valid,
  input  logic [31:0]                res_pc,
  input  logic [31:0]                res_target,
  input  logic                       res_taken,
  output logic                       res_ready,
  input  logic                       fetch_active,
  output logic [PKT_W-1:0]           upd_packet,
  output logic                       upd_strobe,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic                       busy
);

  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int STALL_W = $clog2(STALL_MAX+1);

  sched_state_e     state;
  sched_state_e     state_next;
  logic [STALL_W-1:0] stall_cnt;
  logic             stall_hit;
  logic             load;
  logic             pop;
  logic             coal_hit;
  logic             accept;
  logic             do_push;
  logic             do_coal;
  logic             load_is_tail;
  logic             fifo_full;
  logic             fifo_empty;
  upd_entry_t       head;
  upd_entry_t       second;
  upd_entry_t       push_entry;
  upd_entry_t       load_entry;
  logic [31:0]      tail_pc;

  assign push_entry = '{pc: res_pc, target: res_target};

  btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk              (clk),
    .rst_n            (rst_n),
    .push             (do_push),
    .push_data        (push_entry),
    .pop              (pop),
    .overwrite        (do_coal),
    .overwrite_target (res_target),
    .head             (head),
    .second           (second),
    .tail_pc          (tail_pc),
    .full             (fifo_full),
    .empty            (fifo_empty),
    .count            (q_count)
  );

`ifdef BTB_UPD_COALESCE_EN
  logic tail_free;
  // The tail is in flight only when it is also the head and a sequence has started.
  assign tail_free = (q_count >= CNT_W'(2)) || ((q_count == CNT_W'(1)) && (state == IDLE));
  assign coal_hit  = tail_free && (res_pc == tail_pc);
`else
  logic unused_tail;
  assign unused_tail = ^tail_pc;
  assign coal_hit    = 1'b0 & unused_tail;
`endif

  assign res_ready = !fifo_full || coal_hit;
  assign accept    = res_valid && res_ready && res_taken;
  assign do_coal   = accept && coal_hit;
  assign do_push   = accept && !coal_hit;
  assign stall_hit = (stall_cnt == STALL_W'(STALL_MAX));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && (!fetch_active || stall_hit)) begin
          state_next = DRIVE;
          load       = 1'b1;
        end
      end
      DRIVE:   state_next = PULSE;
      PULSE:   state_next = RECOVER;
      RECOVER: begin
        pop = 1'b1;
        if ((q_count > CNT_W'(1)) && (!fetch_active || stall_hit)) begin
          state_next = DRIVE;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // From RECOVER the head is popped on the same edge, so the next packet comes from the entry behind it.
  // A merge landing on that same entry this cycle must be forwarded, or the stale target would be sent.
  always_comb begin
    load_entry   = (state == RECOVER) ? second : head;
    load_is_tail = (state == RECOVER) ? (q_count == CNT_W'(2)) : (q_count == CNT_W'(1));
    if (do_coal && load_is_tail) load_entry.target = res_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (load || fifo_empty) begin
      stall_cnt <= '0;
    end else if (((state == IDLE) || (state == RECOVER)) && fetch_active && !stall_hit) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_packet <= '0;
      upd_strobe <= 1'b0;
    end else begin
      if (load) upd_packet <= pack_upd(load_entry);
      upd_strobe <= (state_next == PULSE);
    end
  end

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Self-checking bench for btb_update_scheduler: vector table plus scoreboard of expected packets.
// The merge sequence runs only when BTB_UPD_COALESCE_EN is defined.
module tb_btb_update_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        res_valid = 1'b0;
  logic [31:0] res_pc = '0;
  logic [31:0] res_target = '0;
  logic        res_taken = 1'b0;
  logic        fetch_active = 1'b0;
  logic        res_ready;
  logic [63:0] upd_packet;
  logic        upd_strobe;
  logic [2:0]  q_count;
  logic        busy;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_strobe = -1;
  logic [63:0] sb [$];
  int          strobe_cyc [$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
    int          exp_q;
    int          exp_strobes;
  } vec_t;

  vec_t vecs [5];

  btb_update_scheduler #(.DEPTH(4), .STALL_MAX(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .res_valid    (res_valid),
    .res_pc       (res_pc),
    .res_target   (res_target),
    .res_taken    (res_taken),
    .res_ready    (res_ready),
    .fetch_active (fetch_active),
    .upd_packet   (upd_packet),
    .upd_strobe   (upd_strobe),
    .q_count      (q_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every strobe is matched against the oldest expected packet.
  always @(negedge clk) begin
    if (rst_n && upd_strobe) begin
      strobe_cyc.push_back(cyc);
      if (sb.size() == 0) chk("unexpected_strobe", 64'(upd_strobe), 64'd0);
      else                chk("packet", upd_packet, sb.pop_front());
      if (last_strobe >= 0) chk("strobe_gap_ge3", 64'((cyc - last_strobe) >= 3), 64'd1);
      last_strobe = cyc;
    end
  end

  task automatic send(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                      input bit expect_pkt, output int acc);
    bit ok = 0;
    int n = 0;
    res_valid  = 1'b1;
    res_pc     = pc;
    res_target = tgt;
    res_taken  = taken;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = res_ready;
      @(posedge clk);
      #1;
      n++;
    end
    res_valid = 1'b0;
    res_taken = 1'b0;
    acc = cyc;
    if (!ok) chk("accept_timeout", 64'(ok), 64'd1);
    else if (expect_pkt && taken) sb.push_back({pc, tgt});
  endtask

  task automatic wait_drain(input int budget);
    bit done = 0;
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      done = (q_count == 3'd0) && !busy;
      n++;
    end
    chk("drained", 64'(done), 64'd1);
  endtask

  initial begin
    int acc;
    int s0;
    int idx0;
    int drive_cyc;
    bit seen;

    vecs[0] = '{pc: 32'h0000_1004, tgt: 32'h0000_2000, taken: 1'b1, exp_q: 1, exp_strobes: 1};
    vecs[1] = '{pc: 32'h0000_0040, tgt: 32'h0000_0044, taken: 1'b0, exp_q: 0, exp_strobes: 0};
    vecs[2] = '{pc: 32'hFFFF_FFFC, tgt: 32'hDEAD_BEEF, taken: 1'b1, exp_q: 1, exp_strobes: 1};
    vecs[3] = '{pc: 32'h0000_0007, tgt: 32'h8000_0001, taken: 1'b1, exp_q: 1, exp_strobes: 1};
    vecs[4] = '{pc: 32'h0000_0080, tgt: 32'h0000_0100, taken: 1'b0, exp_q: 0, exp_strobes: 0};

    // Reset values with reset held
    #12;
    chk("rst_strobe", 64'(upd_strobe), 64'd0);
    chk("rst_packet", upd_packet, 64'd0);
    chk("rst_qcount", 64'(q_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(res_ready), 64'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single results, each drained before the next
    for (int i = 0; i < 5; i++) begin
      s0 = strobe_cyc.size();
      send(vecs[i].pc, vecs[i].tgt, vecs[i].taken, 1'b1, acc);
      chk("vec_qcount_after_accept", 64'(q_count), 64'(vecs[i].exp_q));
      wait_drain(20);
      repeat (4) @(negedge clk);
      chk("vec_strobes", 64'(strobe_cyc.size() - s0), 64'(vecs[i].exp_strobes));
      chk("vec_qcount_idle", 64'(q_count), 64'd0);
      if (vecs[i].taken && strobe_cyc.size() > s0)
        chk("vec_latency", 64'(strobe_cyc[s0] - acc), 64'd2);
      @(posedge clk);
      #1;
    end

    // Fill the queue back-to-back; the fifth waits for the first pop
    idx0 = strobe_cyc.size();
    send(32'h100, 32'h1100, 1'b1, 1'b1, acc);
    send(32'h200, 32'h1200, 1'b1, 1'b1, acc);
    send(32'h300, 32'h1300, 1'b1, 1'b1, acc);
    send(32'h400, 32'h1400, 1'b1, 1'b1, acc);
    res_valid = 1'b1; res_pc = 32'h500; res_target = 32'h1500; res_taken = 1'b1;
    @(negedge clk);
    chk("full_qcount", 64'(q_count), 64'd4);
    chk("full_ready", 64'(res_ready), 64'd0);
    send(32'h500, 32'h1500, 1'b1, 1'b1, acc);
    wait_drain(40);
    chk("fill_strobe_count", 64'(strobe_cyc.size() - idx0), 64'd5);
    if (strobe_cyc.size() - idx0 == 5)
      for (int k = 1; k < 5; k++)
        chk("fill_spacing", 64'(strobe_cyc[idx0+k] - strobe_cyc[idx0+k-1]), 64'd3);
    @(posedge clk);
    #1;

    // Fetch held busy: forced issue after the stall limit, then the limit restarts
    fetch_active = 1'b1;
    idx0 = strobe_cyc.size();
    send(32'h600, 32'h1600, 1'b1, 1'b1, acc);
    send(32'h700, 32'h1700, 1'b1, 1'b1, s0);
    seen = 0;
    drive_cyc = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1;
        drive_cyc = cyc;
      end
    end
    chk("stall_drive_seen", 64'(seen), 64'd1);
    chk("stall_drive_delay", 64'(drive_cyc - acc), 64'd16);
    wait_drain(60);
    fetch_active = 1'b0;
    chk("stall_strobe_count", 64'(strobe_cyc.size() - idx0), 64'd2);
    if (strobe_cyc.size() - idx0 == 2)
      chk("stall_restart_gap", 64'(strobe_cyc[idx0+1] - strobe_cyc[idx0]), 64'd18);
    @(posedge clk);
    #1;

    // Reset asserted during PULSE
    send(32'h900, 32'h0A00, 1'b1, 1'b1, acc);
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = upd_strobe;
    end
    chk("pulse_seen", 64'(seen), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_strobe", 64'(upd_strobe), 64'd0);
    chk("async_rst_qcount", 64'(q_count), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_packet", upd_packet, 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    s0 = strobe_cyc.size();
    repeat (20) @(negedge clk);
    chk("post_rst_no_strobe", 64'(strobe_cyc.size() - s0), 64'd0);
    chk("post_rst_idle", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

`ifdef BTB_UPD_COALESCE_EN
    // Same-PC results merge into the tail while a different entry is in flight
    send(32'h500, 32'h600, 1'b1, 1'b1, acc);
    send(32'h80, 32'h100, 1'b1, 1'b0, acc);
    send(32'h80, 32'h200, 1'b1, 1'b1, acc);
    chk("coalesce_qcount", 64'(q_count), 64'd2);
    wait_drain(30);
    @(posedge clk);
    #1;
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
